// File: rtl/ps2_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// ps2_rx_ctrl_if
//
// Byte delivery bus between the PS/2 receive frame controller and the
// keyboard decode logic.
//
// Signals:
//   rx_data    [7:0]  received byte, stable while rx_valid is high
//   rx_valid          byte available, held until accepted
//   rx_ready          consumer accepts the byte when rx_valid && rx_ready
//   frame_err         one-cycle pulse on parity, stop or timeout error
//   overrun           one-cycle pulse when a good frame is dropped
//   busy              receiver is inside a frame
//
// Modports:
//   master  - the frame controller (drives data/status, reads rx_ready)
//   slave   - the consumer (reads data/status, drives rx_ready)
// -----------------------------------------------------------------------------
interface ps2_rx_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   modport master (
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun,
      output busy,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      input  busy,
      output rx_ready
   );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// -----------------------------------------------------------------------------
// ps2_rx_ctrl
//
// Receive-side frame controller for a PS/2 device. The raw PS/2 clock and
// data lines are brought into the clk domain through flip-flop
// synchronizers, falling edges of the PS/2 clock are turned into a
// single-cycle strobe, and an FSM captures the 11-bit frame
// (start, 8 data bits LSB first, odd parity, stop). Good bytes are handed to
// the consumer over a valid/ready handshake; bad frames and dropped frames
// are reported with one-cycle pulses. A partial frame is abandoned when no
// PS/2 clock edge arrives for TIMEOUT_CYCLES clk cycles.
//
// Parameters:
//   TIMEOUT_CYCLES  clk cycles without a PS/2 falling edge before a partial
//                   frame is aborted (16..65535)
//   SYNC_STAGES     depth of each input synchronizer (>= 2)
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst_n      synchronous, active-low reset
//   ps2_clk    raw PS/2 clock line (asynchronous)
//   ps2_data   raw PS/2 data line (asynchronous)
//   bus        delivery bus (master side): rx_data, rx_valid, rx_ready,
//              frame_err, overrun, busy
// -----------------------------------------------------------------------------
module ps2_rx_ctrl #(
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ps2_clk,
   input  logic                 ps2_data,
   ps2_rx_ctrl_if.master        bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // Terminal count of the inactivity counter.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   // --------------------------------------------------------------------------
   // Input synchronizers and falling-edge detection
   // --------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] clk_sync_reg;
   logic [SYNC_STAGES-1:0] data_sync_reg;
   logic                   clk_prev_reg;

   // The lines enter at bit 0 and leave at the MSB. Everything presets to 1,
   // the idle bus level, so leaving reset can never fake a falling edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync_reg  <= '1;
         data_sync_reg <= '1;
         clk_prev_reg  <= 1'b1;
      end else begin
         clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
         data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
         clk_prev_reg  <= clk_sync_reg[SYNC_STAGES-1];
      end
   end

   logic ps2_clk_s;
   logic ps2_bit_s;
   logic strb;

   assign ps2_clk_s = clk_sync_reg[SYNC_STAGES-1];
   assign ps2_bit_s = data_sync_reg[SYNC_STAGES-1];
   // High for exactly one cycle per PS/2 falling edge; the device guarantees
   // data is stable around its falling clock edge, so ps2_bit_s is sampled
   // in this same cycle. Both lines go through equal-depth synchronizers.
   assign strb      = clk_prev_reg & ~ps2_clk_s;

   // --------------------------------------------------------------------------
   // Frame FSM, timeout and delivery
   // --------------------------------------------------------------------------
   state_t      state_reg;
   logic [2:0]  bit_cnt_reg;
   logic [7:0]  shreg_reg;
   logic        parity_reg;
   logic [15:0] to_cnt_reg;
   logic [7:0]  rx_data_reg;
   logic        rx_valid_reg;
   logic        frame_err_reg;
   logic        overrun_reg;
   logic        busy_reg;

   // Evaluated in the stop-bit strobe cycle: stop must be 1 and the eight
   // data bits plus the parity bit must hold an odd number of ones.
   logic frame_good;
   assign frame_good = ps2_bit_s & (^{shreg_reg, parity_reg});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= 3'd0;
         shreg_reg     <= 8'h00;
         parity_reg    <= 1'b0;
         to_cnt_reg    <= 16'd0;
         rx_data_reg   <= 8'h00;
         rx_valid_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         // Status pulses last a single cycle.
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;

         // Consumer takes the held byte. A delivery in the same cycle
         // below overrides this and keeps rx_valid high.
         if (rx_valid_reg && bus.rx_ready) begin
            rx_valid_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               to_cnt_reg <= 16'd0;
               // A falling edge with data high is a line glitch, not a
               // start bit; it is silently ignored.
               if (strb && !ps2_bit_s) begin
                  state_reg   <= DATA;
                  bit_cnt_reg <= 3'd0;
                  busy_reg    <= 1'b1;
               end
            end

            DATA, PARITY, STOP: begin
               if (strb) begin
                  // A real edge always beats the timeout terminal count.
                  to_cnt_reg <= 16'd0;
                  case (state_reg)
                     DATA: begin
                        shreg_reg   <= {ps2_bit_s, shreg_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                           state_reg <= PARITY;
                        end
                     end
                     PARITY: begin
                        parity_reg <= ps2_bit_s;
                        state_reg  <= STOP;
                     end
                     default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        if (frame_good) begin
                           // Load when the holding register is empty or is
                           // being emptied in this very cycle; otherwise
                           // the new byte is lost and reported.
                           if (!rx_valid_reg || bus.rx_ready) begin
                              rx_data_reg  <= shreg_reg;
                              rx_valid_reg <= 1'b1;
                           end else begin
                              overrun_reg <= 1'b1;
                           end
                        end else begin
                           frame_err_reg <= 1'b1;
                        end
                     end
                  endcase
               end else if (to_cnt_reg == TO_LAST) begin
                  // Device stopped clocking mid-frame: abandon it.
                  state_reg     <= IDLE;
                  busy_reg      <= 1'b0;
                  frame_err_reg <= 1'b1;
                  to_cnt_reg    <= 16'd0;
               end else begin
                  to_cnt_reg <= to_cnt_reg + 16'd1;
               end
            end

            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx_data   = rx_data_reg;
   assign bus.rx_valid  = rx_valid_reg;
   assign bus.frame_err = frame_err_reg;
   assign bus.overrun   = overrun_reg;
   assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
`timescale 1ns/1ps
module tb_ps2_rx_ctrl;

   localparam int TO   = 40;   // small timeout keeps the run short
   localparam int SS   = 2;    // synchronizer depth
   localparam int HALF = 8;    // PS/2 half period in clk cycles

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic ps2_clk  = 1'b1;
   logic ps2_data = 1'b1;

   ps2_rx_ctrl_if bus();

   ps2_rx_ctrl #(
      .TIMEOUT_CYCLES(TO),
      .SYNC_STAGES   (SS)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_cmp     = 0;
   int n_bad     = 0;
   int cyc       = 0;
   int err_cnt   = 0;
   int ovr_cnt   = 0;
   int err_cyc   = -1;
   int last_fall = 0;

   logic [7:0] exp_q[$];
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops the scoreboard on every accepted byte, checks that a
   // pending byte is held unchanged, and tallies status pulses.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (bus.frame_err) begin
            err_cnt++;
            err_cyc = cyc;
            $display("[%0d] frame_err pulse", cyc);
         end
         if (bus.overrun) begin
            ovr_cnt++;
            $display("[%0d] overrun pulse", cyc);
         end
         if (prev_hold) begin
            n_cmp++;
            assert (bus.rx_valid === 1'b1 && bus.rx_data === prev_data)
            else begin
               n_bad++;
               $error("FAIL hold: valid=%b data=%h, required valid=1 data=%h",
                      bus.rx_valid, bus.rx_data, prev_data);
            end
         end
         if (bus.rx_valid && bus.rx_ready) begin
            n_cmp++;
            assert (exp_q.size() != 0)
            else begin
               n_bad++;
               $error("FAIL unexpected_byte: got %h, required none", bus.rx_data);
            end
            if (exp_q.size() != 0) begin
               logic [7:0] e;
               e = exp_q.pop_front();
               n_cmp++;
               assert (bus.rx_data === e)
               else begin
                  n_bad++;
                  $error("FAIL rx_data: got %h, required %h", bus.rx_data, e);
               end
               $display("[%0d] byte accepted %h (expected %h)", cyc, bus.rx_data, e);
            end
         end
         prev_hold = bus.rx_valid && !bus.rx_ready;
         prev_data = bus.rx_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
      end
   endtask

   // One PS/2 bit: data set while the clock is high, then a falling edge.
   task automatic send_bit(input logic b);
      ps2_data = b;
      repeat (HALF) step();
      ps2_clk   = 1'b0;
      last_fall = cyc;
      repeat (HALF) step();
      ps2_clk = 1'b1;
   endtask

   // Full frame. par_flip corrupts the odd parity bit. With ready_at_stop
   // the consumer raises rx_ready exactly in the stop-bit strobe cycle
   // (SS cycles after the pin edge is registered by the first stage).
   task automatic send_frame(input logic [7:0] d, input logic par_flip,
                             input logic stop, input logic ready_at_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit((~^d) ^ par_flip);
      ps2_data = stop;
      repeat (HALF) step();
      ps2_clk   = 1'b0;
      last_fall = cyc;
      if (ready_at_stop) begin
         repeat (SS) step();
         bus.rx_ready = 1'b1;
         step();
         chk("acc_load_valid", {31'd0, bus.rx_valid}, 32'd1);
         chk("acc_load_data", {24'd0, bus.rx_data}, {24'd0, d});
         step();
         chk("acc_load_drop", {31'd0, bus.rx_valid}, 32'd0);
         repeat (HALF - SS - 2) step();
      end else begin
         repeat (HALF) step();
      end
      ps2_clk = 1'b1;
   endtask

   initial begin
      logic [7:0] b5a;
      b5a = 8'h5A;
      bus.rx_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
      chk("rst_data", {24'd0, bus.rx_data}, 32'd0);
      chk("rst_err", {31'd0, bus.frame_err}, 32'd0);
      chk("rst_ovr", {31'd0, bus.overrun}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      rst_n = 1'b1;
      step();

      // Good frame with consumer always ready.
      exp_q.push_back(8'h1C);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      chk("1c_err", err_cnt, 0);
      chk("1c_valid_gone", {31'd0, bus.rx_valid}, 32'd0);

      // Parity error, error pulse one cycle after the stop strobe.
      send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
      chk("par_err_cnt", err_cnt, 1);
      chk("par_err_time", err_cyc - last_fall, SS + 1);
      chk("par_no_valid", {31'd0, bus.rx_valid}, 32'd0);
      exp_q.push_back(8'hF0);
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      chk("f0_err", err_cnt, 1);

      // Stop bit 0, then a glitch edge in IDLE.
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      chk("stop_err_cnt", err_cnt, 2);
      send_bit(1'b1);
      chk("glitch_busy", {31'd0, bus.busy}, 32'd0);
      chk("glitch_err", err_cnt, 2);

      // Partial frame: start + 5 data bits, then silence.
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(b5a[i]);
      chk("to_busy_mid", {31'd0, bus.busy}, 32'd1);
      repeat (TO + 10) step();
      chk("to_err_cnt", err_cnt, 3);
      chk("to_err_time", err_cyc - last_fall, SS + 1 + TO);
      chk("to_busy_after", {31'd0, bus.busy}, 32'd0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      chk("5a_err", err_cnt, 3);

      // Overrun: consumer stalled for two frames.
      bus.rx_ready = 1'b0;
      exp_q.push_back(8'h1C);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      chk("ovr_none_yet", ovr_cnt, 0);
      send_frame(8'h32, 1'b0, 1'b1, 1'b0);
      chk("ovr_cnt", ovr_cnt, 1);
      chk("ovr_no_err", err_cnt, 3);
      chk("ovr_valid", {31'd0, bus.rx_valid}, 32'd1);
      chk("ovr_data", {24'd0, bus.rx_data}, 32'h1C);
      bus.rx_ready = 1'b1;
      step();
      chk("ovr_drop", {31'd0, bus.rx_valid}, 32'd0);
      chk("ovr_q_empty", exp_q.size(), 0);

      // Accept and load in the same cycle.
      bus.rx_ready = 1'b0;
      exp_q.push_back(8'h21);
      send_frame(8'h21, 1'b0, 1'b1, 1'b0);
      exp_q.push_back(8'h66);
      send_frame(8'h66, 1'b0, 1'b1, 1'b1);
      chk("acc_load_ovr", ovr_cnt, 1);

      // Reset in the middle of a frame.
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rst_n = 1'b0;
      step();
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("mid_rst_data", {24'd0, bus.rx_data}, 32'd0);
      chk("mid_rst_valid", {31'd0, bus.rx_valid}, 32'd0);
      rst_n = 1'b1;
      repeat (TO + 10) step();
      chk("mid_rst_no_err", err_cnt, 3);
      exp_q.push_back(8'h29);
      send_frame(8'h29, 1'b0, 1'b1, 1'b0);

      repeat (20) step();
      chk("final_q_empty", exp_q.size(), 0);
      chk("final_err", err_cnt, 3);
      chk("final_ovr", ovr_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
